// File: rtl/seg_text_buffer.sv
// Eight-digit scrolling text buffer for a seven-segment display, with backspace,
// a digit-at-a-time clear sequence and a blinking cursor on the rightmost decimal point.
module seg_text_buffer #(
   parameter int BLINK_CYCLES = 50000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  char_code,
   input  logic        char_valid,
   output logic        char_ready,
   input  logic        bksp,
   input  logic        clr,
   input  logic        cursor_en,
   output logic [63:0] seg_in,
   output logic [3:0]  char_cnt
);

   localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state;
   state_t          next_state;
   logic [63:0]     disp_q;
   logic [3:0]      cnt_q;
   logic [2:0]      clr_idx;
   logic [BW-1:0]   blink_cnt;
   logic            blink_phase;
   logic [7:0]      enc_byte;

   // Segment patterns as {a,b,c,d,e,f,g,dp}; dp is never lit by a character.
   function automatic logic [7:0] encode(input logic [5:0] code);
      logic [7:0] pat;
      case (code)
         6'd0:  pat = 8'hFC;  6'd1:  pat = 8'h60;  6'd2:  pat = 8'hDA;
         6'd3:  pat = 8'hF2;  6'd4:  pat = 8'h66;  6'd5:  pat = 8'hB6;
         6'd6:  pat = 8'hBE;  6'd7:  pat = 8'hE0;  6'd8:  pat = 8'hFE;
         6'd9:  pat = 8'hF6;  6'd10: pat = 8'hEE;  6'd11: pat = 8'h3E;
         6'd12: pat = 8'h9C;  6'd13: pat = 8'h7A;  6'd14: pat = 8'h9E;
         6'd15: pat = 8'h8E;  6'd16: pat = 8'hBC;  6'd17: pat = 8'h6E;
         6'd18: pat = 8'h0C;  6'd19: pat = 8'h78;  6'd20: pat = 8'hAE;
         6'd21: pat = 8'h1C;  6'd22: pat = 8'hA8;  6'd23: pat = 8'h2A;
         6'd24: pat = 8'h3A;  6'd25: pat = 8'hCE;  6'd26: pat = 8'hE6;
         6'd27: pat = 8'h0A;  6'd28: pat = 8'hB6;  6'd29: pat = 8'h1E;
         6'd30: pat = 8'h7C;  6'd31: pat = 8'h38;  6'd32: pat = 8'h54;
         6'd33: pat = 8'h6E;  6'd34: pat = 8'h76;  6'd35: pat = 8'hDA;
         6'd36: pat = 8'h00;
         default: pat = 8'h02;
      endcase
      return pat;
   endfunction

   assign enc_byte = encode(char_code);
   assign char_cnt = cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (clr) next_state = CLEAR;
         CLEAR:   if (clr_idx == 3'd7) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      char_ready = (state == IDLE);
      seg_in     = disp_q;
      seg_in[0]  = cursor_en && (state == IDLE) && blink_phase;
   end

   // Request priority in IDLE is clr, then bksp, then char_valid; losers are dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp_q  <= 64'h0;
         cnt_q   <= 4'd0;
         clr_idx <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (clr) begin
                  cnt_q   <= 4'd0;
                  clr_idx <= 3'd0;
               end else if (bksp) begin
                  if (cnt_q != 4'd0) begin
                     disp_q <= {8'h00, disp_q[63:8]};
                     cnt_q  <= cnt_q - 4'd1;
                  end
               end else if (char_valid) begin
                  disp_q <= {disp_q[55:0], enc_byte};
                  if (cnt_q != 4'd8) begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            CLEAR: begin
               disp_q[{clr_idx, 3'b000} +: 8] <= 8'h00;
               clr_idx                        <= clr_idx + 3'd1;
            end
            default: begin
               clr_idx <= 3'd0;
            end
         endcase
      end
   end

   // Free-running half-period counter for the cursor, independent of the FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_text_buffer.sv
// Scoreboard bench for seg_text_buffer: a display-level model predicts each cycle's
// outputs, and a negedge monitor compares them against the DUT.
module tb_seg_text_buffer;

   localparam int B = 4;
   localparam logic [7:0] ENC_TAB [0:36] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6,
      8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E, 8'hBC, 8'h6E, 8'h0C, 8'h78,
      8'hAE, 8'h1C, 8'hA8, 8'h2A, 8'h3A, 8'hCE, 8'hE6, 8'h0A, 8'hB6, 8'h1E,
      8'h7C, 8'h38, 8'h54, 8'h6E, 8'h76, 8'hDA, 8'h00};

   typedef struct {
      logic [63:0] seg;
      logic [3:0]  cnt;
      logic        ready;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [5:0]  char_code;
   logic        char_valid;
   logic        char_ready;
   logic        bksp;
   logic        clr;
   logic        cursor_en;
   logic [63:0] seg_in;
   logic [3:0]  char_cnt;

   exp_t        sb[$];
   int          checks = 0;
   int          passes = 0;

   logic [7:0]  disp[8];
   int          m_cnt;
   int          clear_left;
   int          edges;

   seg_text_buffer #(.BLINK_CYCLES(B)) dut (
      .clk        (clk),
      .rst        (rst),
      .char_code  (char_code),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .bksp       (bksp),
      .clr        (clr),
      .cursor_en  (cursor_en),
      .seg_in     (seg_in),
      .char_cnt   (char_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] modelEncode(input int code);
      if (code > 36) return 8'h02;
      return ENC_TAB[code];
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 8; i++) disp[i] = 8'h00;
      m_cnt      = 0;
      clear_left = 0;
      edges      = 0;
   endtask

   function automatic exp_t modelOutputs(input logic ce);
      exp_t e;
      for (int i = 0; i < 8; i++) e.seg[63 - 8*i -: 8] = disp[i];
      e.cnt     = 4'(m_cnt);
      e.ready   = (clear_left == 0);
      e.seg[0]  = ce && (clear_left == 0) && (((edges / B) % 2) == 1);
      return e;
   endfunction

   // disp[0] is the leftmost digit; clear_left counts remaining blanking cycles.
   task automatic modelStep(input logic cv, input int code, input logic bk, input logic cl);
      if (clear_left > 0) begin
         disp[7 - (8 - clear_left)] = 8'h00;
         clear_left--;
      end else if (cl) begin
         m_cnt      = 0;
         clear_left = 8;
      end else if (bk) begin
         if (m_cnt > 0) begin
            for (int i = 7; i > 0; i--) disp[i] = disp[i-1];
            disp[0] = 8'h00;
            m_cnt--;
         end
      end else if (cv) begin
         for (int i = 0; i < 7; i++) disp[i] = disp[i+1];
         disp[7] = modelEncode(code);
         if (m_cnt < 8) m_cnt++;
      end
      edges++;
   endtask

   task automatic applyStimulus(input logic cv, input int code, input logic bk, input logic cl, input logic ce);
      char_valid = cv;
      char_code  = 6'(code);
      bksp       = bk;
      clr        = cl;
      cursor_en  = ce;
      modelStep(cv, code, bk, cl);
      sb.push_back(modelOutputs(ce));
      @(negedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n, input logic ce);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, ce);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("seg_in", seg_in, e.seg);
         checkOutput("char_cnt", {60'b0, char_cnt}, {60'b0, e.cnt});
         checkOutput("char_ready", {63'b0, char_ready}, {63'b0, e.ready});
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic cv, bk, cl, ce;
      rst = 1'b1; char_code = '0; char_valid = 0; bksp = 0; clr = 0; cursor_en = 0;
      #2 rst = 1'b0;
      #1;
      checkOutput("reset_seg", seg_in, 64'h0);
      checkOutput("reset_cnt", {60'b0, char_cnt}, 64'h0);
      modelReset();
      @(negedge clk); #1;
      rst = 1'b1;
      checkOutput("ready_after_reset", {63'b0, char_ready}, 64'h1);

      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 2, 0, 0, 0);
      applyStimulus(1, 3, 0, 0, 0);
      checkOutput("three_chars_seg", seg_in, 64'h000000000060DAF2);
      checkOutput("three_chars_cnt", {60'b0, char_cnt}, 64'd3);

      applyStimulus(0, 0, 0, 1, 0);
      idleCycles(8, 0);
      for (int c = 0; c <= 8; c++) applyStimulus(1, c, 0, 0, 0);
      checkOutput("nine_chars_seg", seg_in, 64'h60DAF266B6BEE0FE);
      checkOutput("nine_chars_cnt", {60'b0, char_cnt}, 64'd8);

      applyStimulus(1, 5, 0, 1, 0);
      checkOutput("clr_ready_low", {63'b0, char_ready}, 64'h0);
      idleCycles(7, 0);
      checkOutput("clr_still_busy", {63'b0, char_ready}, 64'h0);
      idleCycles(1, 0);
      checkOutput("clr_done_seg", seg_in, 64'h0);
      checkOutput("clr_done_ready", {63'b0, char_ready}, 64'h1);

      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 2, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("bksp1_seg", seg_in, 64'h60);
      checkOutput("bksp1_cnt", {60'b0, char_cnt}, 64'd1);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("bksp_empty_seg", seg_in, 64'h0);
      checkOutput("bksp_empty_cnt", {60'b0, char_cnt}, 64'd0);

      idleCycles(12, 1);
      applyStimulus(1, 20, 0, 0, 1);
      applyStimulus(0, 0, 0, 1, 1);
      idleCycles(10, 1);
      idleCycles(6, 0);

      ce = 1'b0;
      for (int i = 0; i < 300; i++) begin
         cv = ($urandom_range(0, 9) < 6);
         bk = ($urandom_range(0, 9) == 0);
         cl = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 15) == 0) ce = ~ce;
         if (clear_left == 0 && !cl && bk && cv && m_cnt == 0) bk = 1'b0;
         applyStimulus(cv, int'($urandom_range(0, 63)), bk, cl, ce);
      end

      applyStimulus(1, 7, 0, 0, 1);
      applyStimulus(0, 0, 0, 1, 1);
      idleCycles(3, 1);
      rst = 1'b0;
      #1;
      checkOutput("async_reset_seg", seg_in, 64'h0);
      checkOutput("async_reset_cnt", {60'b0, char_cnt}, 64'h0);
      checkOutput("async_reset_ready", {63'b0, char_ready}, 64'h1);
      modelReset();
      @(negedge clk); @(negedge clk); #1;
      rst = 1'b1;
      checkOutput("ready_after_rerelease", {63'b0, char_ready}, 64'h1);
      idleCycles(10, 1);
      applyStimulus(1, 36, 0, 0, 1);
      applyStimulus(1, 50, 0, 0, 1);

      checkOutput("scoreboard_drained", 64'(sb.size()), 64'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/seg_text_buffer.md
SEG_TEXT_BUFFER -- requirements
Module: seg_text_buffer

Interface
REQ-001 SHALL have parameter BLINK_CYCLES, default 50000000, clk cycles per cursor blink half-period (minimum 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port char_code  input  6  decoded character: 0-9 digits, 10-35 letters A-Z, 36 space, 37-63 undefined.
REQ-005 SHALL have port char_valid  input  1  char_code offered this cycle.
REQ-006 SHALL have port char_ready  output  1  block can accept a character or command this cycle.
REQ-007 SHALL have port bksp  input  1  backspace request, one-cycle strobe.
REQ-008 SHALL have port clr  input  1  clear-display request, one-cycle strobe.
REQ-009 SHALL have port cursor_en  input  1  enables the blinking cursor.
REQ-010 SHALL have port seg_in  output  64  segment patterns for the display multiplexer; [63:56] is the leftmost digit, [7:0] the rightmost.
REQ-011 SHALL have port char_cnt  output  4  number of characters held, 0-8.

Function
REQ-012 SHALL encode each digit byte as {a,b,c,d,e,f,g,dp} in bits 7..0, active-high (1 = lit), with blank = 8'h00.
REQ-013 SHALL map codes 0-9 to FC,60,DA,F2,66,B6,BE,E0,FE,F6 (hex).
REQ-014 SHALL map codes 10-35 (A-Z) to EE,3E,9C,7A,9E,8E,BC,6E,0C,78,AE,1C,A8,2A,3A,CE,E6,0A,B6,1E,7C,38,54,6E,76,DA (hex).
REQ-015 SHALL map code 36 to 8'h00 and codes 37-63 to 8'h02 (dash).
REQ-016 SHALL use a two-state FSM, IDLE and CLEAR; char_ready = 1 in IDLE and 0 in CLEAR.
REQ-017 SHALL, in IDLE, accept a character when char_valid=1: shift the buffer left one digit, discard the leftmost digit, and load the encoded byte into the rightmost digit.
REQ-018 SHALL make the result of any accepted operation visible on seg_in and char_cnt in the cycle after the accepting edge.
REQ-019 SHALL increment char_cnt on each accepted character and saturate it at 8; at 8 the oldest character scrolls off.
REQ-020 SHALL, on bksp in IDLE with char_cnt>0, shift the buffer right one digit, insert blank at the leftmost digit, and decrement char_cnt.
REQ-021 SHALL ignore bksp when char_cnt=0.
REQ-022 SHALL, on clr in IDLE, enter CLEAR and set char_cnt to 0.
REQ-023 SHALL, in CLEAR, blank one digit per cycle, rightmost first (cycle k blanks digit k, k=0..7), and return to IDLE after the 8th cycle.
REQ-024 SHALL resolve simultaneous requests in IDLE with priority clr > bksp > char_valid, and SHALL drop the losing requests without queuing them.
REQ-025 SHALL ignore char_valid, bksp and clr while in CLEAR.
REQ-026 SHALL run a free-running blink counter that toggles a blink phase every BLINK_CYCLES cycles.
REQ-027 SHALL, when cursor_en=1 and the FSM is in IDLE, drive seg_in[0] (rightmost dp) as the blink phase; otherwise seg_in[0] SHALL be 0.
REQ-028 SHALL make the blink phase affect only seg_in[0]; stored buffer contents and all other bits are unaffected.

Reset
REQ-029 SHALL, while rst=0, force seg_in=64'h0, char_cnt=0, FSM=IDLE, blink counter=0 and blink phase=0, independent of clk.
REQ-030 SHALL, on reset asserted mid-CLEAR or mid-operation, abandon the operation and return to the REQ-029 state immediately.
REQ-031 SHALL drive char_ready=1 on the first cycle after rst deasserts.

Verification
REQ-032 SHALL be tested as: reset, cursor_en=0, then accept codes 1,2,3 in three consecutive cycles -> seg_in[23:0]=60DAF2, seg_in[63:24]=0, char_cnt=3.
REQ-033 SHALL be tested as: 9 accepted characters 0..8 -> seg_in = 60DAF266B6BEE0FE, char_cnt=8.
REQ-034 SHALL be tested as: buffer holding "12", bksp -> seg_in[7:0]=60, char_cnt=1; two further bksp -> char_cnt=0, seg_in=0, and the second bksp has no effect.
REQ-035 SHALL be tested as: full buffer, clr together with char_valid -> char_ready=0 for exactly 8 cycles, digits blank rightmost first, char_cnt=0, and the character is not stored.
REQ-036 SHALL be tested as: BLINK_CYCLES=4, cursor_en=1 -> seg_in[0] toggles every 4 cycles; it is held at 0 during CLEAR and at 0 with cursor_en=0.
REQ-037 SHALL be tested as: rst asserted mid-CLEAR and mid-blink -> outputs go to the REQ-029 state without a clock edge.
